// File: rtl/one2n_pkg.sv
// Shared types and defaults for the one2n_tx frame replicator.
// The state list gains S_SEQ when ONE2N_SEQ_EN is defined.
package one2n_pkg;

  localparam int DEF_MAX_LEN = 2048;
  localparam int DEF_IFG     = 12;
  localparam int LEN_W       = $clog2(DEF_MAX_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ID,
    S_DATA,
    S_GAP
`ifdef ONE2N_SEQ_EN
    , S_SEQ
`endif
  } state_t;

  // Length counters must hold the value max_len itself, hence the extra bit.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/one2n_buf.sv
// Frame payload store: simple dual-port RAM, one write port, registered read port.
module one2n_buf
  import one2n_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_q;

  // NOTE: the RAM array has no reset so it maps onto block RAM; every byte is
  // written during load before the transmitter ever reads it.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[rd_addr];
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/one2n_tx.sv
// Stores one input frame, then transmits it N times as id byte + payload with IFG idle cycles between copies.
// Define ONE2N_SEQ_EN to insert a per-frame sequence byte after the id byte.
module one2n_tx
  import one2n_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IFG     = DEF_IFG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_en,
  input  logic [7:0] redundancy,
  output logic       busy,
  output logic [7:0] txd,
  output logic       txen,
  output logic       drop
);

  localparam int LW = len_w(MAX_LEN);
  localparam int AW = $clog2(MAX_LEN);
  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG - 1);

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [7:0]      copy_q, copy_d;
  logic [7:0]      n_q, n_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ovf_q, ovf_d;
  logic            din_en_q;
  logic [7:0]      txd_q, txd_d;
  logic            txen_q, txen_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
`ifdef ONE2N_SEQ_EN
  logic [7:0]      seq_q, seq_d;
`endif

  logic            new_frame;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_data;

  one2n_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Only a rising envelope starts a frame, so the tail of a rejected frame
  // that runs into S_IDLE is never mistaken for a new one.
  assign new_frame = din_en && !din_en_q;

  // Read one address ahead so byte k is on rd_data in the k-th S_DATA cycle.
  assign rd_addr = (state_q == S_DATA) ? idx_q[AW-1:0] + AW'(1) : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    copy_d  = copy_q;
    n_d     = n_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = len_q[AW-1:0];
`ifdef ONE2N_SEQ_EN
    seq_d   = seq_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (new_frame) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = LW'(1);
          ovf_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (din_en) begin
          if (len_q < MAX_LEN_L) begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
          end else if (!ovf_q) begin
            drop_d = 1'b1;
            ovf_d  = 1'b1;
          end
        end else begin
          n_d     = (redundancy == 8'd0) ? 8'd1 : redundancy;
          copy_d  = 8'd1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        txen_d = 1'b1;
        txd_d  = copy_q;
        drop_d = new_frame;
        idx_d  = '0;
`ifdef ONE2N_SEQ_EN
        state_d = S_SEQ;
`else
        state_d = S_DATA;
`endif
      end
`ifdef ONE2N_SEQ_EN
      S_SEQ: begin
        txen_d  = 1'b1;
        txd_d   = seq_q;
        drop_d  = new_frame;
        state_d = S_DATA;
      end
`endif
      S_DATA: begin
        txen_d = 1'b1;
        txd_d  = rd_data;
        drop_d = new_frame;
        if (idx_q == len_q - LW'(1)) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      S_GAP: begin
        drop_d = new_frame;
        if (gap_q == GAP_LAST) begin
          if (copy_q < n_q) begin
            copy_d  = copy_q + 8'd1;
            state_d = S_ID;
          end else begin
            state_d = S_IDLE;
`ifdef ONE2N_SEQ_EN
            seq_d   = seq_q + 8'd1;
`endif
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      copy_q   <= 8'd0;
      n_q      <= 8'd0;
      gap_q    <= '0;
      ovf_q    <= 1'b0;
      din_en_q <= 1'b0;
      txd_q    <= 8'h00;
      txen_q   <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef ONE2N_SEQ_EN
      seq_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      copy_q   <= copy_d;
      n_q      <= n_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
      din_en_q <= din_en;
      txd_q    <= txd_d;
      txen_q   <= txen_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
`ifdef ONE2N_SEQ_EN
      seq_q    <= seq_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign txen = txen_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_one2n_tx.sv
// Directed bench for one2n_tx: copy format and spacing, rejection, overflow, reset abort.
// Sequence-byte checks are active when ONE2N_SEQ_EN is defined.
module tb_one2n_tx;

  localparam int MAXL = 2048;
  localparam int IFGC = 12;
`ifdef ONE2N_SEQ_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 1;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_en;
  logic [7:0] redundancy;
  logic       busy;
  logic [7:0] txd;
  logic       txen;
  logic       drop;

  always #5 clk = ~clk;

  one2n_tx #(.MAX_LEN(MAXL), .IFG(IFGC)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .redundancy (redundancy),
    .busy       (busy),
    .txd        (txd),
    .txen       (txen),
    .drop       (drop)
  );

  int   cyc = 0;
  int   drop_cnt = 0;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;
  bq_t  tx_q;
  int   tx_cyc[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // Output recorder, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (txen === 1'b1) begin
      tx_q.push_back(txd);
      tx_cyc.push_back(cyc);
    end
    if (drop === 1'b1) drop_cnt++;
    if (busy_prev && busy === 1'b0) busy_fall = cyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic clear_mon();
    tx_q.delete();
    tx_cyc.delete();
    busy_fall = -1;
  endtask

  task automatic send_frame(input bq_t p, output int t_end);
    foreach (p[i]) begin
      @(posedge clk); #1;
      din_en = 1'b1;
      din    = p[i];
    end
    @(posedge clk); #1;
    din_en = 1'b0;
    din    = 8'h00;
    t_end  = cyc + 1;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_reach"}, 32'(tx_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, 32'(busy === 1'b0), 1);
    @(posedge clk);
  endtask

  // Expected: ncp copies of {id, [seq], payload}, first id 2 cycles after
  // t_end, IFGC idle cycles between copies, busy low IFGC after last byte.
  task automatic verify(input string tag, input bq_t p, input int ncp, input int seq, input int t_end);
    int  cl;
    int  bad_d;
    int  bad_t;
    bq_t want;
    cl    = p.size() + HDR;
    bad_d = 0;
    bad_t = 0;
    for (int c = 0; c < ncp; c++) begin
      want.push_back(8'(c + 1));
`ifdef ONE2N_SEQ_EN
      want.push_back(8'(seq));
`endif
      foreach (p[i]) want.push_back(p[i]);
    end
    check({tag, "_len"}, tx_q.size(), want.size());
    for (int i = 0; i < want.size() && i < tx_q.size(); i++) begin
      if (tx_q[i] !== want[i]) bad_d++;
      if (tx_cyc[i] != t_end + 2 + (i / cl) * (cl + IFGC) + (i % cl)) bad_t++;
    end
    check({tag, "_data"}, bad_d, 0);
    check({tag, "_time"}, bad_t, 0);
    if (tx_cyc.size() > 0) check({tag, "_busy"}, busy_fall - tx_cyc[tx_cyc.size()-1], IFGC);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, pb, pt;
    int  te, te2, d0, n;

    rst = 1'b1; din_en = 1'b0; din = 8'h00; redundancy = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txen", txen, 0);
    check("rst_txd",  txd,  0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    check("idle_quiet", tx_q.size(), 0);

    // 10-byte frame, three copies; redundancy change after latching is ignored.
    clear_mon(); d0 = drop_cnt;
    p = {}; for (int i = 0; i < 10; i++) p.push_back(8'(i));
    redundancy = 8'd3;
    send_frame(p, te);
    @(posedge clk); #1 redundancy = 8'd7;
    wait_idle("t1", 600);
    verify("t1", p, 3, 0, te);
    check("t1_drop", drop_cnt - d0, 0);

    // redundancy=0 gives one copy; a frame starting in the last gap cycle is rejected.
    clear_mon(); d0 = drop_cnt;
    p = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    redundancy = 8'd0;
    send_frame(p, te);
    wait_tx("t2", 4 + HDR, 100);
    repeat (IFGC - 3) @(posedge clk);
    pb = {8'h55, 8'h56, 8'h57};
    send_frame(pb, te2);
    wait_idle("t2", 100);
    repeat (40) @(posedge clk);
    verify("t2", p, 1, 1, te);
    check("t2_drop", drop_cnt - d0, 1);

    // Second frame arrives during copy 2 of the first.
    clear_mon(); d0 = drop_cnt;
    p = {}; for (int i = 0; i < 10; i++) p.push_back(8'(8'h10 + i));
    redundancy = 8'd3;
    send_frame(p, te);
    wait_tx("t3", 10 + HDR + 2, 200);
    pb = {8'hEE, 8'hED, 8'hEC, 8'hEB, 8'hEA};
    send_frame(pb, te2);
    wait_idle("t3", 600);
    repeat (30) @(posedge clk);
    verify("t3", p, 3, 2, te);
    check("t3_drop", drop_cnt - d0, 1);

    // Oversize frame is truncated to MAXL bytes with a single drop pulse.
    clear_mon(); d0 = drop_cnt;
    p = {}; for (int i = 0; i < MAXL + 5; i++) p.push_back(8'(i * 7 + 3));
    pt = {}; for (int i = 0; i < MAXL; i++) pt.push_back(p[i]);
    redundancy = 8'd1;
    send_frame(p, te);
    wait_idle("t4", 6000);
    verify("t4", pt, 1, 3, te);
    check("t4_drop", drop_cnt - d0, 1);

    // Reset in copy 2 data aborts the frame; the next frame restarts at id 1.
    clear_mon();
    p = {}; for (int i = 0; i < 10; i++) p.push_back(8'(8'h30 + i));
    redundancy = 8'd3;
    send_frame(p, te);
    wait_tx("t5", 10 + HDR + 4, 200);
    #3 rst = 1'b1;
    #1;
    check("t5_txen", txen, 0);
    check("t5_busy", busy, 0);
    n = tx_q.size();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (60) @(posedge clk);
    check("t5_quiet", tx_q.size(), n);
    clear_mon();
    p = {8'hC1, 8'hC2, 8'hC3};
    redundancy = 8'd2;
    send_frame(p, te);
    wait_idle("t5b", 300);
    verify("t5b", p, 2, 0, te);

`ifdef ONE2N_SEQ_EN
    // 257 single-byte frames: sequence byte runs 0..255 then wraps to 0.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    redundancy = 8'd2;
    for (int f = 0; f < 257; f++) begin
      clear_mon();
      p = {8'(f * 3)};
      send_frame(p, te);
      wait_idle("t6", 200);
      verify("t6", p, 2, f % 256, te);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
